// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_seq
// Purpose  : Multi-cycle logical right shifter, one bit per clock, with
//            caller-supplied MSB fill and sticky collection of lost bits.
// Revision : 1.0 - initial release
// ============================================================================
module shift_right_seq #(
    parameter int SWR = 26,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] Data_i,
    input  logic [SHW-1:0] shift_amt_i,
    input  logic           bit_shift_i,
    output logic           busy_o,
    output logic           ready_o,
    output logic [SWR-1:0] Data_o,
    output logic           sticky_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [SHW-1:0] r_count;
    logic           r_fill;
    logic [SWR-1:0] r_data;
    logic           r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = (shift_amt_i == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The edge that sees a count of one performs the final shift.
                if (r_count <= SHW'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_fill   <= 1'b0;
            r_data   <= '0;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_count  <= shift_amt_i;
                        r_fill   <= bit_shift_i;
                        r_data   <= Data_i;
                        r_sticky <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_data   <= {r_fill, r_data[SWR-1:1]};
                    r_sticky <= r_sticky | r_data[0];
                    r_count  <= r_count - SHW'(1);
                end
                default: begin
                    r_data   <= r_data;
                    r_sticky <= r_sticky;
                end
            endcase
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign ready_o  = (r_state == S_DONE);
    assign Data_o   = r_data;
    assign sticky_o = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_right_seq
// Purpose  : Scoreboard bench for shift_right_seq with directed and random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_right_seq;

    localparam int SWR = 26;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic [SWR-1:0] Data_i = '0;
    logic [SHW-1:0] shift_amt_i = '0;
    logic           bit_shift_i = 1'b0;
    logic           busy_o;
    logic           ready_o;
    logic [SWR-1:0] Data_o;
    logic           sticky_o;

    shift_right_seq #(.SWR(SWR), .SHW(SHW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .Data_i      (Data_i),
        .shift_amt_i (shift_amt_i),
        .bit_shift_i (bit_shift_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .Data_o      (Data_o),
        .sticky_o    (sticky_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SWR-1:0] data;
        logic           sticky;
        int             acc;
        int             rdy;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: view the operand as sitting under an endless run of fill
    // bits; the result is the low SWR bits after an arithmetic-free shift.
    function automatic exp_t model(input logic [SWR-1:0] d, input int amt, input logic f);
        exp_t           e;
        logic [63:0]    wide;
        logic [63:0]    lost_mask;
        wide      = {{(64-SWR){f}}, d};
        wide      = wide >> amt;
        lost_mask = (amt >= SWR) ? {64{1'b1}} : ((64'd1 << amt) - 64'd1);
        e.data    = wide[SWR-1:0];
        e.sticky  = |({{(64-SWR){1'b0}}, d} & lost_mask);
        e.acc     = 0;
        e.rdy     = 0;
        return e;
    endfunction

    // Monitor: tracks the busy window and the ready cycle of the head entry.
    always @(negedge clk) begin
        if (!rst) begin
            bit in_win;
            bit rdy_exp;
            in_win  = (sb.size() > 0) && (edge_cnt >= sb[0].acc) && (edge_cnt <= sb[0].rdy);
            rdy_exp = in_win && (edge_cnt == sb[0].rdy);
            check("busy_o", {63'd0, busy_o}, {63'd0, in_win});
            check("ready_o", {63'd0, ready_o}, {63'd0, rdy_exp});
            if (ready_o && rdy_exp) begin
                check("Data_o", {{(64-SWR){1'b0}}, Data_o}, {{(64-SWR){1'b0}}, sb[0].data});
                check("sticky_o", {63'd0, sticky_o}, {63'd0, sb[0].sticky});
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy_o) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: pending %0d busy %0b expected idle", sb.size(), busy_o);
            sb.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // Issues one operation at a negedge; hold > 1 keeps start high into later
    // cycles, mid_pulse re-pulses start with different inputs during SHIFT.
    task automatic issue(input logic [SWR-1:0] d, input int amt, input logic f,
                         input int hold, input bit mid_pulse);
        exp_t e;
        e        = model(d, amt, f);
        e.acc    = edge_cnt + 1;
        e.rdy    = edge_cnt + 1 + amt;
        sb.push_back(e);
        Data_i      = d;
        shift_amt_i = SHW'(amt);
        bit_shift_i = f;
        start_i     = 1'b1;
        for (int i = 0; i < hold; i++) @(negedge clk);
        start_i     = 1'b0;
        Data_i      = ~d;
        bit_shift_i = ~f;
        shift_amt_i = SHW'(amt ^ 5);
        if (mid_pulse) begin
            @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    task automatic run_op(input logic [SWR-1:0] d, input int amt, input logic f);
        issue(d, amt, f, 1, 1'b0);
        wait_idle();
    endtask

    initial begin
        int ready_seen;
        repeat (3) @(negedge clk);
        check("reset_Data_o", {{(64-SWR){1'b0}}, Data_o}, 64'd0);
        check("reset_sticky", {63'd0, sticky_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(26'h2000001, 1, 1'b0);
        run_op(26'h155AAAA, 0, 1'b0);
        run_op(26'h3FFFFFF, 4, 1'b0);
        run_op(26'h3FFFFFF, 4, 1'b1);
        run_op(26'h0000010, 31, 1'b0);
        run_op(26'h0000000, 31, 1'b0);
        run_op(26'h0000040, 6, 1'b0);
        run_op(26'h2AAAAAA, 26, 1'b1);

        // start held into the DONE cycle must be dropped
        issue(26'h0ABCDEF, 0, 1'b0, 2, 1'b0);
        wait_idle();
        // start re-pulsed mid-SHIFT with altered inputs must be ignored
        issue(26'h1234567, 10, 1'b1, 1, 1'b1);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            run_op(SWR'($urandom), int'($urandom_range(0, 31)), 1'($urandom));
        end

        // Reset two SHIFT cycles into an operation
        issue(26'h3C3C3C3, 20, 1'b1, 1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_Data_o", {{(64-SWR){1'b0}}, Data_o}, 64'd0);
        check("abort_sticky", {63'd0, sticky_o}, 64'd0);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_ready", {63'd0, ready_o}, 64'd0);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) ready_seen++;
        end
        check("abort_no_ready", 64'(ready_seen), 64'd0);

        run_op(26'h0000003, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
